// File: rtl/gl_raster_pkg.sv
// gl_raster_pkg: shared types for the edge-function rasterizer.
// FSM state encoding, fragment bundle and edge accumulator width.
package gl_raster_pkg;

  localparam int FRAG_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } raster_state_t;

  typedef struct packed {
    logic [FRAG_W-1:0] x;
    logic [FRAG_W-1:0] y;
    logic              last;
  } frag_t;

  function automatic int edge_w(input int coord_w);
    return 2 * coord_w + 2;
  endfunction

endpackage

// File: rtl/gl_edge_eval.sv
// gl_edge_eval: one incremental edge function E_ab(px,py).
// Loaded at the bbox origin, then stepped in x or down a row.
module gl_edge_eval
  import gl_raster_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_neg,
  input  logic                 i_step_x,
  input  logic                 i_step_y,
  input  logic signed [CW-1:0] i_xa,
  input  logic signed [CW-1:0] i_ya,
  input  logic signed [CW-1:0] i_xb,
  input  logic signed [CW-1:0] i_yb,
  input  logic signed [CW-1:0] i_px,
  input  logic signed [CW-1:0] i_py,
  output logic                 o_ge0
);

  localparam int EW = edge_w(CW);
  typedef logic signed [EW-1:0] edg_t;

  function automatic edg_t ext(input logic signed [CW-1:0] v);
    return {{(EW-CW){v[CW-1]}}, v};
  endfunction

  edg_t w_dx, w_dy, w_e;
  edg_t r_row, r_cur, r_sx, r_sy;

  assign w_dx = ext(i_xb) - ext(i_xa);
  assign w_dy = ext(i_yb) - ext(i_ya);
  assign w_e  = w_dx * (ext(i_py) - ext(i_ya))
              - w_dy * (ext(i_px) - ext(i_xa));

  // clockwise triangles drawn as-is get all signs flipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_cur <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else if (i_load) begin
      r_row <= i_neg ? -w_e : w_e;
      r_cur <= i_neg ? -w_e : w_e;
      r_sx  <= i_neg ? w_dy : -w_dy;
      r_sy  <= i_neg ? -w_dx : w_dx;
    end else if (i_step_y) begin
      r_row <= r_row + r_sy;
      r_cur <= r_row + r_sy;
    end else if (i_step_x) begin
      r_cur <= r_cur + r_sx;
    end
  end

  assign o_ge0 = !r_cur[EW-1];

endmodule

// File: rtl/gl_edge_rasterizer.sv
// gl_edge_rasterizer: integer edge-function triangle rasterizer.
// Bbox walk one pixel/cycle, one-deep hold slot to flag frag_last.
module gl_edge_rasterizer
  import gl_raster_pkg::*;
#(
  parameter int COORD_W   = 12,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter bit CULL_BACK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  input  logic signed [COORD_W-1:0] x2,
  input  logic signed [COORD_W-1:0] y2,
  input  logic signed [COORD_W-1:0] x3,
  input  logic signed [COORD_W-1:0] y3,
  output logic                      frag_valid,
  input  logic                      frag_ready,
  output logic [COORD_W-1:0]        frag_x,
  output logic [COORD_W-1:0]        frag_y,
  output logic                      frag_last,
  output logic                      tri_done,
  output logic                      tri_culled
);

  localparam int EDGE_W = edge_w(COORD_W);
  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [EDGE_W-1:0] edg_t;
  localparam crd_t ZERO = '0;
  localparam crd_t ONE  = crd_t'(1);
  localparam crd_t XMAX = crd_t'(SCREEN_W - 1);
  localparam crd_t YMAX = crd_t'(SCREEN_H - 1);

  function automatic edg_t ext(input crd_t v);
    return {{(EDGE_W-COORD_W){v[COORD_W-1]}}, v};
  endfunction
  function automatic crd_t cmin(input crd_t a, input crd_t b);
    return (a < b) ? a : b;
  endfunction
  function automatic crd_t cmax(input crd_t a, input crd_t b);
    return (a > b) ? a : b;
  endfunction

  raster_state_t r_state;
  crd_t  r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  crd_t  r_minx, r_maxx, r_maxy, r_x, r_y, r_hx, r_hy;
  logic  r_hold_v, r_eos, r_cull, r_out_v;
  frag_t r_out;

  edg_t  w_area;
  crd_t  w_minx, w_maxx, w_miny, w_maxy;
  logic  w_neg, w_cull, w_load, w_in, w_free, w_test;
  logic  w_hit, w_adv, w_push, w_flush, w_eol;
  logic  w_ge12, w_ge23, w_ge31;

  assign w_area = (ext(r_x2) - ext(r_x1)) * (ext(r_y3) - ext(r_y1))
                - (ext(r_y2) - ext(r_y1)) * (ext(r_x3) - ext(r_x1));
  assign w_minx = cmax(cmin(cmin(r_x1, r_x2), r_x3), ZERO);
  assign w_maxx = cmin(cmax(cmax(r_x1, r_x2), r_x3), XMAX);
  assign w_miny = cmax(cmin(cmin(r_y1, r_y2), r_y3), ZERO);
  assign w_maxy = cmin(cmax(cmax(r_y1, r_y2), r_y3), YMAX);
  assign w_neg  = w_area[EDGE_W-1];
  assign w_cull = (w_area == '0) || (w_neg && CULL_BACK)
               || (w_minx > w_maxx) || (w_miny > w_maxy);

  assign w_load  = (r_state == SETUP);
  assign w_in    = w_ge12 && w_ge23 && w_ge31;
  assign w_test  = (r_state == SCAN) && !r_eos;
  assign w_hit   = w_test && w_in;
  assign w_free  = !r_out_v || frag_ready;
  assign w_adv   = w_test && !(w_hit && r_hold_v && !w_free);
  assign w_push  = w_adv && w_hit && r_hold_v;
  assign w_flush = (r_state == SCAN) && r_eos && r_hold_v && w_free;
  assign w_eol   = (r_x == r_maxx);

  gl_edge_eval #(.CW(COORD_W)) u_e12 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load),
    .i_neg(w_neg && !CULL_BACK),
    .i_step_x(w_adv && !w_eol), .i_step_y(w_adv && w_eol),
    .i_xa(r_x1), .i_ya(r_y1), .i_xb(r_x2), .i_yb(r_y2),
    .i_px(w_minx), .i_py(w_miny), .o_ge0(w_ge12)
  );
  gl_edge_eval #(.CW(COORD_W)) u_e23 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load),
    .i_neg(w_neg && !CULL_BACK),
    .i_step_x(w_adv && !w_eol), .i_step_y(w_adv && w_eol),
    .i_xa(r_x2), .i_ya(r_y2), .i_xb(r_x3), .i_yb(r_y3),
    .i_px(w_minx), .i_py(w_miny), .o_ge0(w_ge23)
  );
  gl_edge_eval #(.CW(COORD_W)) u_e31 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load),
    .i_neg(w_neg && !CULL_BACK),
    .i_step_x(w_adv && !w_eol), .i_step_y(w_adv && w_eol),
    .i_xa(r_x3), .i_ya(r_y3), .i_xb(r_x1), .i_yb(r_y1),
    .i_px(w_minx), .i_py(w_miny), .o_ge0(w_ge31)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x1 <= '0; r_y1 <= '0; r_x2 <= '0;
      r_y2 <= '0; r_x3 <= '0; r_y3 <= '0;
      r_minx <= '0; r_maxx <= '0; r_maxy <= '0;
      r_x <= '0; r_y <= '0;
      r_eos <= 1'b0;
      r_cull <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (tri_valid) begin
          r_x1 <= x1; r_y1 <= y1; r_x2 <= x2;
          r_y2 <= y2; r_x3 <= x3; r_y3 <= y3;
          r_state <= SETUP;
        end
        SETUP: begin
          r_minx  <= w_minx;
          r_maxx  <= w_maxx;
          r_maxy  <= w_maxy;
          r_x     <= w_minx;
          r_y     <= w_miny;
          r_eos   <= 1'b0;
          r_cull  <= w_cull;
          r_state <= w_cull ? DONE : SCAN;
        end
        SCAN: begin
          if (w_adv) begin
            if (w_eol) begin
              r_x <= r_minx;
              if (r_y == r_maxy) r_eos <= 1'b1;
              else               r_y   <= r_y + ONE;
            end else begin
              r_x <= r_x + ONE;
            end
          end
          // retire only once the final fragment has left
          if (r_eos && !r_hold_v && w_free) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_v <= 1'b0;
      r_hx <= '0;
      r_hy <= '0;
      r_out_v <= 1'b0;
      r_out <= '0;
    end else begin
      if (w_adv && w_hit) begin
        r_hold_v <= 1'b1;
        r_hx <= r_x;
        r_hy <= r_y;
      end else if (w_flush) begin
        r_hold_v <= 1'b0;
      end
      if (w_push || w_flush) begin
        r_out_v    <= 1'b1;
        r_out.x    <= FRAG_W'(r_hx);
        r_out.y    <= FRAG_W'(r_hy);
        r_out.last <= w_flush;
      end else if (frag_ready) begin
        r_out_v <= 1'b0;
      end
    end
  end

  assign tri_ready  = (r_state == IDLE);
  assign tri_done   = (r_state == DONE);
  assign tri_culled = (r_state == DONE) && r_cull;
  assign frag_valid = r_out_v;
  assign frag_x     = COORD_W'(r_out.x);
  assign frag_y     = COORD_W'(r_out.y);
  assign frag_last  = r_out_v && r_out.last;

endmodule

// File: tb/tb_gl_edge_rasterizer.sv
// Bench: two rasterizers (cull on / cull off) on shared stimulus,
// scoreboarded against a per-pixel edge-function model.
module tb_gl_edge_rasterizer;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic tri_valid = 1'b0;
  logic frag_ready = 1'b1;
  logic signed [CW-1:0] x1 = '0, y1 = '0, x2 = '0;
  logic signed [CW-1:0] y2 = '0, x3 = '0, y3 = '0;
  logic tri_ready[2], frag_valid[2], frag_last[2];
  logic tri_done[2], tri_culled[2];
  logic [CW-1:0] frag_x[2], frag_y[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gl_edge_rasterizer #(
      .COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480),
      .CULL_BACK(g == 0)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .tri_valid(tri_valid), .tri_ready(tri_ready[g]),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .frag_valid(frag_valid[g]), .frag_ready(frag_ready),
      .frag_x(frag_x[g]), .frag_y(frag_y[g]),
      .frag_last(frag_last[g]),
      .tri_done(tri_done[g]), .tri_culled(tri_culled[g])
    );
  end

  typedef struct {int x; int y; bit last;} ef_t;
  ef_t fq[2][$];
  bit  dq[2][$];
  int  total = 0;
  int  bad = 0;
  int  nfrag[2];
  bit  bp_arm = 0;
  int  bp_cnt = 0;
  bit  rnd_bp = 0;
  bit  pv[2];
  int  px_[2], py_[2], pl_[2];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int ef(input int ax, ay, bx, by, px, py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic int mn3(input int a, b, c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int mx3(input int a, b, c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  task automatic push_exp(input int ax, ay, bx, by, cx, cy);
    int area, lx, hx, ly, hy, n0, e1, e2, e3;
    bit cull, in;
    area = ef(ax, ay, bx, by, cx, cy);
    lx = mn3(ax, bx, cx); if (lx < 0) lx = 0;
    ly = mn3(ay, by, cy); if (ly < 0) ly = 0;
    hx = mx3(ax, bx, cx); if (hx > 639) hx = 639;
    hy = mx3(ay, by, cy); if (hy > 479) hy = 479;
    for (int g = 0; g < 2; g++) begin
      cull = (area == 0) || (area < 0 && g == 0) || lx > hx || ly > hy;
      n0 = fq[g].size();
      if (!cull)
        for (int y = ly; y <= hy; y++)
          for (int x = lx; x <= hx; x++) begin
            e1 = ef(ax, ay, bx, by, x, y);
            e2 = ef(bx, by, cx, cy, x, y);
            e3 = ef(cx, cy, ax, ay, x, y);
            in = (area > 0) ? (e1 >= 0 && e2 >= 0 && e3 >= 0)
                            : (e1 <= 0 && e2 <= 0 && e3 <= 0);
            if (in) fq[g].push_back('{x, y, 1'b0});
          end
      if (fq[g].size() > n0) fq[g][fq[g].size()-1].last = 1'b1;
      dq[g].push_back(cull);
    end
  endtask

  task automatic monitor();
    ef_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv[0] = 0;
        pv[1] = 0;
        continue;
      end
      if (bp_cnt > 0) begin
        bp_cnt--;
        if (bp_cnt == 0) frag_ready = 1'b1;
      end else if (bp_arm && frag_valid[0] && nfrag[0] == 2) begin
        frag_ready = 1'b0;
        bp_cnt = 5;
        bp_arm = 0;
      end else if (rnd_bp) begin
        frag_ready = ($urandom_range(3) != 0);
      end
      for (int g = 0; g < 2; g++) begin
        if (pv[g]) begin
          chk("hold_valid", int'(frag_valid[g]), 1);
          chk("hold_x", int'(frag_x[g]), px_[g]);
          chk("hold_y", int'(frag_y[g]), py_[g]);
          chk("hold_last", int'(frag_last[g]), pl_[g]);
        end
        if (frag_valid[g] && frag_ready) begin
          nfrag[g]++;
          if (fq[g].size() == 0) begin
            chk("extra_frag", int'(frag_x[g]), -1);
          end else begin
            e = fq[g].pop_front();
            chk("frag_x", int'(frag_x[g]), e.x);
            chk("frag_y", int'(frag_y[g]), e.y);
            chk("frag_last", int'(frag_last[g]), int'(e.last));
          end
        end
        if (tri_done[g]) begin
          if (dq[g].size() == 0) chk("extra_done", 1, 0);
          else chk("culled", int'(tri_culled[g]), int'(dq[g].pop_front()));
        end else if (tri_culled[g]) begin
          chk("culled_no_done", 1, 0);
        end
        pv[g] = frag_valid[g] && !frag_ready;
        px_[g] = int'(frag_x[g]);
        py_[g] = int'(frag_y[g]);
        pl_[g] = int'(frag_last[g]);
      end
    end
  endtask

  task automatic send(input int ax, ay, bx, by, cx, cy);
    int t = 0;
    while (!(tri_ready[0] && tri_ready[1]) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("ready_timeout", 0, 1);
    x1 = CW'(ax); y1 = CW'(ay); x2 = CW'(bx);
    y2 = CW'(by); x3 = CW'(cx); y3 = CW'(cy);
    nfrag[0] = 0;
    nfrag[1] = 0;
    push_exp(ax, ay, bx, by, cx, cy);
    tri_valid = 1'b1;
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((dq[0].size() != 0 || dq[1].size() != 0) && t < 20000) begin
      @(posedge clk); t++;
    end
    if (t >= 20000) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("missing_frag0", fq[0].size(), 0);
    chk("missing_frag1", fq[1].size(), 0);
  endtask

  initial begin
    int ax, ay, bx, by, cx, cy, off_x, off_y;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", int'(tri_ready[g]), 1);
      chk("rst_fvalid", int'(frag_valid[g]), 0);
      chk("rst_done", int'(tri_done[g]) + int'(tri_culled[g]), 0);
      chk("rst_fxy", int'(frag_x[g]) + int'(frag_y[g]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork monitor(); join_none

    send(0, 0, 4, 0, 0, 4);
    wait_done();
    chk("c1_cnt0", nfrag[0], 15);
    chk("c1_cnt1", nfrag[1], 15);

    send(0, 0, 0, 4, 4, 0);
    @(posedge clk);
    @(negedge clk);
    chk("c2_done_t2", int'(tri_done[0]), 1);
    chk("c2_cull_t2", int'(tri_culled[0]), 1);
    wait_done();
    chk("c2_cnt0", nfrag[0], 0);
    chk("c2_cnt1", nfrag[1], 15);

    send(0, 0, 2, 2, 5, 5);
    wait_done();
    chk("c3a_cnt", nfrag[0] + nfrag[1], 0);
    send(-10, -10, -2, -10, -10, -2);
    wait_done();
    chk("c3b_cnt", nfrag[0] + nfrag[1], 0);

    send(-3, -3, 8, -3, -3, 8);
    wait_done();
    chk("c4_cnt0", nfrag[0], 21);
    chk("c4_cnt1", nfrag[1], 21);

    bp_arm = 1;
    send(0, 0, 4, 0, 0, 4);
    wait_done();
    chk("c5_cnt", nfrag[0], 15);

    send(0, 0, 4, 0, 0, 4);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      fq[g].delete();
      dq[g].delete();
    end
    #2;
    for (int g = 0; g < 2; g++) begin
      chk("c6_ready", int'(tri_ready[g]), 1);
      chk("c6_out", int'(frag_valid[g]) + int'(tri_done[g])
                  + int'(frag_last[g]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(0, 0, 4, 0, 0, 4);
    wait_done();
    chk("c6_cnt", nfrag[0], 15);

    rnd_bp = 1;
    for (int i = 0; i < 16; i++) begin
      off_x = (i >= 12) ? 620 : 0;
      off_y = (i >= 12) ? 460 : 0;
      ax = int'($urandom_range(32)) - 8 + off_x;
      ay = int'($urandom_range(32)) - 8 + off_y;
      bx = int'($urandom_range(32)) - 8 + off_x;
      by = int'($urandom_range(32)) - 8 + off_y;
      cx = int'($urandom_range(32)) - 8 + off_x;
      cy = int'($urandom_range(32)) - 8 + off_y;
      send(ax, ay, bx, by, cx, cy);
      wait_done();
    end
    rnd_bp = 0;
    frag_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
